// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch (F) and memory (M) stages: IDLE/BUSY/DONE sequencer
// with req/ack handshake, pipeline stall and watchdog. Define MEMARB_FAIR_EN for alternating grant on ties.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_f,
  input  logic [ADDR_W-1:0] if_addr_f,
  output logic [DATA_W-1:0] if_rdata_f,
  output logic              if_valid_f,
  input  logic              memread_m,
  input  logic              memwrite_m,
  input  logic [ADDR_W-1:0] addr_m,
  input  logic [DATA_W-1:0] wdata_m,
  input  logic [3:0]        be_m,
  output logic [DATA_W-1:0] rdata_m,
  output logic              valid_m,
  output logic              stall_pipe,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [DATA_W-1:0] NOP     = DATA_W'(32'h0000_0013);
  localparam logic [7:0]        WD_LAST = 8'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;   // 1 = M owns the access
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic [7:0]          wd_q, wd_d;
  logic [DATA_W-1:0]   frd_q, frd_d;
  logic [DATA_W-1:0]   mrd_q, mrd_d;
  logic                terr_q, terr_d;
  logic                pend_m, grant_m;

  assign pend_m = memread_m | memwrite_m;

`ifdef MEMARB_FAIR_EN
  logic last_q, last_d;   // 1 = M was granted last
  // On a tie, fetch wins only if the data stage had the previous grant.
  assign grant_m = pend_m & ~(if_req_f & last_q);
`else
  assign grant_m = pend_m;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wd_d    = wd_q;
    frd_d   = frd_q;
    mrd_d   = mrd_q;
    terr_d  = terr_q;
`ifdef MEMARB_FAIR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pend_m | if_req_f) begin
          owner_d = grant_m;
          req_d   = 1'b1;
          wd_d    = 8'd0;
          state_d = BUSY;
`ifdef MEMARB_FAIR_EN
          last_d  = grant_m;
`endif
          if (grant_m) begin
            addr_d  = addr_m;
            wdata_d = wdata_m;
            be_d    = be_m;
            we_d    = memwrite_m;
          end else begin
            addr_d  = if_addr_f;
            be_d    = 4'b1111;
            we_d    = 1'b0;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!owner_q)    frd_d = mem_rdata;
          else if (!we_q)  mrd_d = mem_rdata;
        end else if (wd_q == WD_LAST) begin
          // Watchdog abort: fetch gets a nop so the pipeline keeps moving.
          req_d   = 1'b0;
          terr_d  = 1'b1;
          state_d = DONE;
          if (!owner_q)    frd_d = NOP;
          else if (!we_q)  mrd_d = '0;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'b0;
      wd_q    <= 8'd0;
      frd_q   <= '0;
      mrd_q   <= '0;
      terr_q  <= 1'b0;
`ifdef MEMARB_FAIR_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      frd_q   <= frd_d;
      mrd_q   <= mrd_d;
      terr_q  <= terr_d;
`ifdef MEMARB_FAIR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign if_valid_f  = (state_q == DONE) & ~owner_q;
  assign valid_m     = (state_q == DONE) &  owner_q;
  assign if_rdata_f  = frd_q;
  assign rdata_m     = mrd_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_be      = be_q;
  assign timeout_err = terr_q;
  assign stall_pipe  = (pend_m & ~valid_m) | (if_req_f & ~if_valid_f);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized accesses
// checked against a transaction-level model (winner, latency, fields, returned data).
module tb_mem_port_arbiter;
  localparam int TO = 15;

  logic        clk = 1'b0, reset = 1'b1;
  logic        if_req_f = 1'b0, memread_m = 1'b0, memwrite_m = 1'b0;
  logic [31:0] if_addr_f = '0, addr_m = '0, wdata_m = '0;
  logic [3:0]  be_m = '0;
  logic [31:0] if_rdata_f, rdata_m, mem_addr, mem_wdata;
  logic        if_valid_f, valid_m, stall_pipe, mem_req, mem_we, timeout_err;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req_f(if_req_f), .if_addr_f(if_addr_f), .if_rdata_f(if_rdata_f), .if_valid_f(if_valid_f),
    .memread_m(memread_m), .memwrite_m(memwrite_m), .addr_m(addr_m), .wdata_m(wdata_m), .be_m(be_m),
    .rdata_m(rdata_m), .valid_m(valid_m), .stall_pipe(stall_pipe),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // memory responder: acks after wait_n request cycles (wait_n < 0 = never)
  int          wait_n = 0, req_cnt = 0;
  bit          stray_ack = 1'b0, ovr_en = 1'b0;
  logic [31:0] ovr_dat = '0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  always @(negedge clk) begin
    mem_ack   = stray_ack;
    mem_rdata = 32'hDEAD_BEEF;
    if (mem_req) begin
      if (wait_n >= 0 && req_cnt == wait_n) begin
        mem_ack   = 1'b1;
        mem_rdata = ovr_en ? ovr_dat : mem_fn(mem_addr);
      end
      req_cnt++;
    end else req_cnt = 0;
  end

  // reference model state
  bit          exp_last = 1'b0;   // 1 = M granted last
  logic [31:0] exp_frd = '0, exp_mrd = '0;

  function automatic bit m_wins_tie();
`ifdef MEMARB_FAIR_EN
    return !exp_last;
`else
    return 1'b1;
`endif
  endfunction

  // observation of one access, starting in the cycle the request is visible
  int          obs_lat, obs_reqlat, obs_reqcnt;
  bit          obs_f, obs_m, obs_stable, obs_stall_pre, obs_stall_v;
  logic [31:0] obs_addr, obs_wdata, obs_fdat, obs_mdat;
  logic        obs_we;
  logic [3:0]  obs_be;

  task automatic observe(input int budget);
    bit seen = 1'b0;
    obs_f = 0; obs_m = 0; obs_lat = -1; obs_reqlat = -1; obs_reqcnt = 0;
    obs_stable = 1; obs_stall_pre = 1; obs_stall_v = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (mem_req) begin
        obs_reqcnt++;
        if (!seen) begin
          seen = 1; obs_reqlat = k;
          obs_addr = mem_addr; obs_wdata = mem_wdata; obs_we = mem_we; obs_be = mem_be;
        end else if (mem_addr !== obs_addr || mem_wdata !== obs_wdata || mem_we !== obs_we || mem_be !== obs_be)
          obs_stable = 0;
      end
      if (if_valid_f || valid_m) begin
        obs_f = if_valid_f; obs_m = valid_m; obs_fdat = if_rdata_f; obs_mdat = rdata_m;
        obs_lat = k; obs_stall_v = stall_pipe;
        break;
      end
      if (stall_pipe !== 1'b1) obs_stall_pre = 0;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stray_ack = 0; wait_n = 0;
    repeat (2) @(negedge clk);
    total++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL rst_req got=%b/%b exp=0/0", mem_req, mem_we); end
    total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0) begin bad++; $display("FAIL rst_fields got=%h/%h/%h exp=0", mem_addr, mem_wdata, mem_be); end
    total++; if (if_valid_f !== 1'b0 || valid_m !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b/%b exp=0/0", if_valid_f, valid_m); end
    total++; if (if_rdata_f !== 32'h0 || rdata_m !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h/%h exp=0", if_rdata_f, rdata_m); end
    total++; if (timeout_err !== 1'b0 || stall_pipe !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b/%b exp=0/0", timeout_err, stall_pipe); end
    reset = 1'b0;
    exp_last = 0; exp_frd = '0; exp_mrd = '0;
    next_cycle();
  endtask

  task automatic test_fetch();
    wait_n = 0; ovr_en = 1; ovr_dat = 32'h0050_0093;
    if_req_f = 1; if_addr_f = 32'h0000_0100;
    observe(20);
    total++; if (obs_reqlat != 1) begin bad++; $display("FAIL fetch_reqlat got=%0d exp=1", obs_reqlat); end
    total++; if (!(obs_f && !obs_m) || obs_lat != 2) begin bad++; $display("FAIL fetch_valid got=%b%b@%0d exp=10@2", obs_f, obs_m, obs_lat); end
    total++; if (obs_fdat !== 32'h0050_0093) begin bad++; $display("FAIL fetch_data got=%h exp=00500093", obs_fdat); end
    total++; if (obs_addr !== 32'h100 || obs_we !== 1'b0 || obs_be !== 4'hF) begin bad++; $display("FAIL fetch_fields got=%h/%b/%h exp=100/0/f", obs_addr, obs_we, obs_be); end
    total++; if (!obs_stall_pre || obs_stall_v !== 1'b0) begin bad++; $display("FAIL fetch_stall got=%b/%b exp=1/0", obs_stall_pre, obs_stall_v); end
    ovr_en = 0; exp_frd = 32'h0050_0093; exp_last = 0;
    next_cycle(); if_req_f = 0;
    @(negedge clk);
    total++; if (stall_pipe !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL fetch_after got=%b/%b exp=0/0", stall_pipe, mem_req); end
    next_cycle();
  endtask

  task automatic test_priority();
    bit mfirst;
    // a load first so the last owner is M
    wait_n = 0; memread_m = 1; addr_m = 32'h0000_0200; be_m = 4'hF;
    observe(20);
    total++; if (!obs_m || obs_mdat !== mem_fn(32'h200)) begin bad++; $display("FAIL prio_load got=%b/%h exp=1/%h", obs_m, obs_mdat, mem_fn(32'h200)); end
    exp_last = 1; exp_mrd = mem_fn(32'h200);
    next_cycle(); memread_m = 0;
    next_cycle();
    // simultaneous
    if_req_f = 1; if_addr_f = 32'h0000_0300; memread_m = 1; addr_m = 32'h40;
    mfirst = m_wins_tie();
    observe(20);
    total++; if (obs_m != mfirst || obs_f == mfirst || obs_lat != 2) begin bad++; $display("FAIL prio_first got=m%b f%b@%0d exp=m%b@2", obs_m, obs_f, obs_lat, mfirst); end
    total++; if (obs_addr !== (mfirst ? 32'h40 : 32'h300)) begin bad++; $display("FAIL prio_addr got=%h exp=%h", obs_addr, mfirst ? 32'h40 : 32'h300); end
    total++; if (obs_stall_v !== 1'b1) begin bad++; $display("FAIL prio_stall got=%b exp=1", obs_stall_v); end
    next_cycle();
    if (mfirst) memread_m = 0; else if_req_f = 0;
    observe(20);
    total++; if (obs_m == mfirst || obs_reqlat != 1 || obs_lat != 2) begin bad++; $display("FAIL prio_second got=m%b req@%0d v@%0d exp=m%b req@1 v@2", obs_m, obs_reqlat, obs_lat, !mfirst); end
    total++; if (obs_fdat !== mem_fn(32'h300) || obs_mdat !== mem_fn(32'h40)) begin bad++; $display("FAIL prio_data got=%h/%h exp=%h/%h", obs_fdat, obs_mdat, mem_fn(32'h300), mem_fn(32'h40)); end
    exp_frd = mem_fn(32'h300); exp_mrd = mem_fn(32'h40); exp_last = !mfirst;
    next_cycle(); if_req_f = 0; memread_m = 0;
  endtask

  task automatic test_store();
    wait_n = 2; memwrite_m = 1; addr_m = 32'h0000_0081; be_m = 4'b0010; wdata_m = 32'h0000_AB00;
    observe(20);
    total++; if (!obs_m || obs_reqlat != 1 || obs_lat != 4) begin bad++; $display("FAIL sb_timing got=m%b req@%0d v@%0d exp=1/1/4", obs_m, obs_reqlat, obs_lat); end
    total++; if (obs_we !== 1'b1 || obs_be !== 4'b0010 || obs_wdata !== 32'h0000_AB00 || obs_addr !== 32'h81) begin bad++; $display("FAIL sb_fields got=%b/%h/%h/%h exp=1/2/0000ab00/81", obs_we, obs_be, obs_wdata, obs_addr); end
    total++; if (!obs_stable || obs_reqcnt != 3) begin bad++; $display("FAIL sb_stable got=%b/%0d exp=1/3", obs_stable, obs_reqcnt); end
    total++; if (obs_mdat !== exp_mrd) begin bad++; $display("FAIL sb_rdata got=%h exp=%h", obs_mdat, exp_mrd); end
    exp_last = 1;
    next_cycle(); memwrite_m = 0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int kind, mode, n;
      bit f_on, m_on, m_wr, mw;
      logic [31:0] fa, da, wd;
      logic [3:0] be;
      kind = $urandom_range(0, 2); mode = $urandom_range(0, 2);
      fa = $urandom; da = $urandom; wd = $urandom;
      be = ($urandom_range(0, 1) != 0) ? 4'hF : 4'(1 << $urandom_range(0, 3));
      f_on = (kind != 1); m_on = (kind != 0); m_wr = (mode != 0);
      if_req_f = f_on; if_addr_f = fa;
      memread_m = m_on && (mode != 1); memwrite_m = m_on && (mode != 0);
      addr_m = da; wdata_m = wd; be_m = be;
      n = int'(f_on) + int'(m_on);
      for (int j = 0; j < n; j++) begin
        int w;
        mw = (f_on && m_on) ? m_wins_tie() : m_on;
        w = $urandom_range(0, 3); wait_n = w;
        observe(20);
        total++; if (obs_m != mw || obs_f == mw || obs_reqlat != 1 || obs_lat != w + 2) begin bad++; $display("FAIL rnd_grant it=%0d got=m%b f%b req@%0d v@%0d exp=m%b req@1 v@%0d", it, obs_m, obs_f, obs_reqlat, obs_lat, mw, w + 2); end
        total++; if (obs_addr !== (mw ? da : fa) || obs_we !== (mw && m_wr) || obs_be !== (mw ? be : 4'hF) || !obs_stable) begin bad++; $display("FAIL rnd_fields it=%0d got=%h/%b/%h/%b exp=%h/%b/%h/1", it, obs_addr, obs_we, obs_be, obs_stable, mw ? da : fa, mw && m_wr, mw ? be : 4'hF); end
        if (mw) begin
          if (!m_wr) exp_mrd = mem_fn(da);
          else begin
            total++; if (obs_wdata !== wd) begin bad++; $display("FAIL rnd_wdata it=%0d got=%h exp=%h", it, obs_wdata, wd); end
          end
        end else exp_frd = mem_fn(fa);
        total++; if (obs_fdat !== exp_frd || obs_mdat !== exp_mrd) begin bad++; $display("FAIL rnd_data it=%0d got=%h/%h exp=%h/%h", it, obs_fdat, obs_mdat, exp_frd, exp_mrd); end
        total++; if (obs_stall_v !== (mw ? f_on : m_on) || !obs_stall_pre) begin bad++; $display("FAIL rnd_stall it=%0d got=%b/%b exp=%b/1", it, obs_stall_v, obs_stall_pre, mw ? f_on : m_on); end
        exp_last = mw;
        next_cycle();
        if (mw) begin m_on = 0; memread_m = 0; memwrite_m = 0; end
        else begin f_on = 0; if_req_f = 0; end
      end
    end
  endtask

  task automatic test_timeout();
    wait_n = -1; if_req_f = 1; if_addr_f = 32'h0000_0400;
    observe(40);
    total++; if (!obs_f || obs_lat != TO + 1) begin bad++; $display("FAIL to_fetch_lat got=%b@%0d exp=1@%0d", obs_f, obs_lat, TO + 1); end
    total++; if (obs_fdat !== 32'h0000_0013 || timeout_err !== 1'b1) begin bad++; $display("FAIL to_fetch_data got=%h/%b exp=00000013/1", obs_fdat, timeout_err); end
    exp_frd = 32'h13; exp_last = 0;
    next_cycle(); if_req_f = 0;
    memread_m = 1; addr_m = 32'h44; be_m = 4'hF;
    observe(40);
    total++; if (!obs_m || obs_lat != TO + 1 || obs_mdat !== 32'h0) begin bad++; $display("FAIL to_load got=%b@%0d/%h exp=1@%0d/0", obs_m, obs_lat, obs_mdat, TO + 1); end
    exp_mrd = '0; exp_last = 1;
    next_cycle(); memread_m = 0;
    wait_n = 1; if_req_f = 1; if_addr_f = 32'h500;
    observe(20);
    total++; if (obs_lat != 3 || obs_fdat !== mem_fn(32'h500) || timeout_err !== 1'b1) begin bad++; $display("FAIL to_sticky got=%0d/%h/%b exp=3/%h/1", obs_lat, obs_fdat, timeout_err, mem_fn(32'h500)); end
    exp_frd = mem_fn(32'h500); exp_last = 0;
    next_cycle(); if_req_f = 0;
  endtask

  task automatic test_reset_busy();
    bit vseen = 0, rseen = 0;
    wait_n = -1; if_req_f = 1; if_addr_f = 32'h600;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++; if (mem_req !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL rb_async got=%b/%b exp=0/0", mem_req, timeout_err); end
    @(negedge clk); if_req_f = 0; reset = 1'b0;
    exp_last = 0; exp_frd = '0; exp_mrd = '0;
    stray_ack = 1;
    repeat (4) begin
      @(negedge clk);
      if (if_valid_f || valid_m) vseen = 1;
      if (mem_req) rseen = 1;
    end
    stray_ack = 0;
    total++; if (vseen || rseen) begin bad++; $display("FAIL rb_quiet got=v%b r%b exp=v0 r0", vseen, rseen); end
    total++; if (if_rdata_f !== 32'h0 || rdata_m !== 32'h0) begin bad++; $display("FAIL rb_rdata got=%h/%h exp=0/0", if_rdata_f, rdata_m); end
    next_cycle();
    wait_n = 0; if_req_f = 1; if_addr_f = 32'h700;
    observe(20);
    total++; if (obs_reqlat != 1 || obs_lat != 2 || obs_fdat !== mem_fn(32'h700)) begin bad++; $display("FAIL rb_idle got=%0d/%0d/%h exp=1/2/%h", obs_reqlat, obs_lat, obs_fdat, mem_fn(32'h700)); end
    next_cycle(); if_req_f = 0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_random();
    test_timeout();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
